// File: rtl/dmem_arb.sv
// Two-port arbiter for a single-port data memory: core port A and loader/DMA port B.
// Round-robin on conflict, optional locked ownership bounded by MAXBURST, address range check.
module dmem_arb #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAXBURST = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e          state_q, state_d;
  logic            lastb_q, lastb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            a_rvalid_q, b_rvalid_q;
  logic [31:0]     a_rdata_q, b_rdata_q;
  logic            gnt_a, gnt_b;
  logic            err_a, err_b;

  // Arbitration, ownership and burst limiting
  always_comb begin
    state_d = state_q;
    lastb_d = lastb_q;
    cnt_d   = cnt_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          gnt_a   = lastb_q;
          gnt_b   = !lastb_q;
          lastb_d = !lastb_q;
        end else begin
          gnt_a = a_req;
          gnt_b = b_req;
        end
        if (gnt_a && a_lock) begin
          if (b_req && (MAXBURST <= 1)) begin
            lastb_d = 1'b0;
          end else begin
            state_d = OWN_A;
            cnt_d   = CW'(b_req);
          end
        end else if (gnt_b && b_lock) begin
          if (a_req && (MAXBURST <= 1)) begin
            lastb_d = 1'b1;
          end else begin
            state_d = OWN_B;
            cnt_d   = CW'(a_req);
          end
        end
      end
      OWN_A: begin
        gnt_a = a_req;
        if (!a_req || !a_lock) begin
          state_d = IDLE;
        end else if (b_req) begin
          if ((32'(cnt_q) + 32'd1) >= MAXBURST) begin
            state_d = IDLE;
            lastb_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      OWN_B: begin
        gnt_b = b_req;
        if (!b_req || !b_lock) begin
          state_d = IDLE;
        end else if (a_req) begin
          if ((32'(cnt_q) + 32'd1) >= MAXBURST) begin
            state_d = IDLE;
            lastb_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the combinational grant path immediately
    if (!rst_n) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  assign err_a     = gnt_a && (a_addr >= 32'(DEPTH));
  assign err_b     = gnt_b && (b_addr >= 32'(DEPTH));
  assign a_gnt     = gnt_a;
  assign b_gnt     = gnt_b;
  assign a_err     = err_a;
  assign b_err     = err_b;
  assign mem_addr  = gnt_b ? b_addr  : a_addr;
  assign mem_wdata = gnt_b ? b_wdata : a_wdata;
  assign mem_we    = (gnt_a && a_we && !err_a) || (gnt_b && b_we && !err_b);
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lastb_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lastb_q <= lastb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read return: out-of-range reads complete with zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= gnt_a && !a_we;
      b_rvalid_q <= gnt_b && !b_we;
      if (gnt_a && !a_we) a_rdata_q <= err_a ? 32'd0 : mem_rdata;
      if (gnt_b && !b_we) b_rdata_q <= err_b ? 32'd0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: directed scenarios plus random traffic against a rule-level model.
module tb_dmem_arb;
  localparam int unsigned DEPTH    = 64;
  localparam int unsigned MAXBURST = 8;
  localparam int unsigned AW       = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, a_lock = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic        b_req = 0, b_we = 0, b_lock = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_we;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arb #(.DEPTH(DEPTH), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's own copy
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  always @(posedge clk) if (mem_we && mem_addr < 32'(DEPTH)) mem[mem_addr[AW-1:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[AW-1:0]] : 32'hBAD0_BAD0;

  typedef struct { int stamp; logic [31:0] data; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] held_a = 0, held_b = 0;
  int  owner = -1;
  bit  m_lastb = 1'b1;
  int  run = 0;
  bit  last_ga, last_gb;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic mon_port(input bit pb, input logic rv, input logic [31:0] rd);
    exp_t e;
    bit have;
    have = pb ? (qb.size() > 0) : (qa.size() > 0);
    if (have) e = pb ? qb[0] : qa[0];
    while (have && e.stamp < cyc) begin
      checks++; failures++;
      $display("FAIL rvalid_missing port=%0d stamp=%0d got=0 exp=1", pb, e.stamp);
      if (pb) void'(qb.pop_front()); else void'(qa.pop_front());
      have = pb ? (qb.size() > 0) : (qa.size() > 0);
      if (have) e = pb ? qb[0] : qa[0];
    end
    if (rv) begin
      if (!have || e.stamp != cyc) begin
        checks++; failures++;
        $display("FAIL rvalid_unexpected port=%0d cyc=%0d got=1 exp=0", pb, cyc);
      end else begin
        chk(pb ? "b_rdata" : "a_rdata", rd, e.data);
        if (pb) begin held_b = e.data; void'(qb.pop_front()); end
        else begin held_a = e.data; void'(qa.pop_front()); end
      end
    end else if (have && e.stamp == cyc) begin
      checks++; failures++;
      $display("FAIL rvalid_missing port=%0d stamp=%0d got=0 exp=1", pb, e.stamp);
      if (pb) void'(qb.pop_front()); else void'(qa.pop_front());
    end else begin
      chk(pb ? "b_rdata_hold" : "a_rdata_hold", rd, pb ? held_b : held_a);
    end
  endtask

  // Monitor: pops expected read returns whenever rvalid shows up
  always @(posedge clk) begin
    #1;
    cyc++;
    mon_port(1'b0, a_rvalid, a_rdata);
    mon_port(1'b1, b_rvalid, b_rdata);
  end

  task automatic model_reset();
    owner = -1; m_lastb = 1'b1; run = 0; held_a = 0; held_b = 0;
  endtask

  // One cycle of stimulus; the model derives grants from the arbitration rules
  task automatic step(input bit ar, aw, al, input logic [31:0] aa, ad,
                      input bit br, bw, bl, input logic [31:0] ba, bd);
    bit req[2], lk[2], g[2], e[2], we[2];
    logic [31:0] ad_[2], dt_[2];
    int w, x;
    @(negedge clk);
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    req[0] = ar; req[1] = br; lk[0] = al; lk[1] = bl; we[0] = aw; we[1] = bw;
    ad_[0] = aa; ad_[1] = ba; dt_[0] = ad; dt_[1] = bd;
    g[0] = 0; g[1] = 0;
    if (owner < 0) begin
      w = -1;
      if (req[0] && req[1]) begin w = m_lastb ? 0 : 1; m_lastb = (w == 1); end
      else if (req[0]) w = 0;
      else if (req[1]) w = 1;
      if (w >= 0) begin
        g[w] = 1;
        if (lk[w]) begin
          if (req[1-w] && MAXBURST <= 1) m_lastb = (w == 1);
          else begin owner = w; run = req[1-w] ? 1 : 0; end
        end
      end
    end else begin
      x = owner;
      g[x] = req[x];
      if (!req[x] || !lk[x]) owner = -1;
      else if (req[1-x]) begin
        run++;
        if (run >= MAXBURST) begin owner = -1; m_lastb = (x == 1); end
      end else run = 0;
    end
    for (int p = 0; p < 2; p++) e[p] = g[p] && (ad_[p] >= 32'(DEPTH));
    #1;
    last_ga = a_gnt; last_gb = b_gnt;
    chk("a_gnt", 32'(a_gnt), 32'(g[0]));
    chk("b_gnt", 32'(b_gnt), 32'(g[1]));
    chk("a_err", 32'(a_err), 32'(e[0]));
    chk("b_err", 32'(b_err), 32'(e[1]));
    chk("mem_we", 32'(mem_we), 32'((g[0] && we[0] && !e[0]) || (g[1] && we[1] && !e[1])));
    for (int p = 0; p < 2; p++) begin
      if (g[p]) begin
        chk("mem_addr", mem_addr, ad_[p]);
        if (we[p] && !e[p]) begin
          chk("mem_wdata", mem_wdata, dt_[p]);
          ref_mem[ad_[p][AW-1:0]] = dt_[p];
        end else if (!we[p]) begin
          if (p == 0) qa.push_back('{cyc + 1, e[p] ? 32'd0 : ref_mem[ad_[p][AW-1:0]]});
          else        qb.push_back('{cyc + 1, e[p] ? 32'd0 : ref_mem[ad_[p][AW-1:0]]});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; a_we = 0; b_we = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cmp_mem(input string name);
    int diffs;
    diffs = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(name, 32'(diffs), 32'd0);
  endtask

  initial begin
    int na;
    bit got_b;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    // Requests held high during reset must not be granted
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_b_gnt", 32'(b_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    @(negedge clk);
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    rst_n = 1'b1;

    // Simultaneous reads of addr 5: A first, then B
    step(1, 0, 0, 5, 0, 1, 0, 0, 5, 0);
    chk("conf_a_first", 32'(last_ga), 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
    chk("conf_b_second", 32'(last_gb), 1);
    idle(2);

    // Write through A, read back through B
    step(1, 1, 0, 10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 10, 0);
    idle(1);
    chk("wr_rd_b_rdata", b_rdata, 32'hDEADBEEF);

    // Locked A burst against a waiting B
    do_reset();
    na = 0; got_b = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, 32'(i), 0, 1, 0, 0, 20, 0);
      if (!got_b) begin
        if (last_ga) na++;
        if (last_gb) got_b = 1;
      end
    end
    chk("burst_a_grants", 32'(na), 32'(MAXBURST));
    chk("burst_b_granted", 32'(got_b), 1);
    idle(2);

    // Out-of-range write suppressed, out-of-range read returns zero
    step(0, 0, 0, 0, 0, 1, 1, 0, 64, 32'h1234_5678);
    idle(1);
    cmp_mem("oob_mem_unchanged");
    step(0, 0, 0, 0, 0, 1, 0, 0, 70, 0);
    idle(1);
    chk("oob_b_rdata", b_rdata, 0);

    // Reset while B owns the memory
    do_reset();
    step(0, 0, 0, 0, 0, 1, 1, 1, 3, 32'hCAFE0003);
    @(negedge clk);
    a_req = 1; a_we = 0; a_lock = 0; a_addr = 6;
    b_req = 1; b_we = 1; b_lock = 1; b_addr = 4; b_wdata = 32'h0BAD0004;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midlock_a_gnt", 32'(a_gnt), 0);
    chk("midlock_b_gnt", 32'(b_gnt), 0);
    chk("midlock_mem_we", 32'(mem_we), 0);
    @(negedge clk);
    chk("midlock_mem4", mem[4], ref_mem[4]);
    chk("midlock_mem3", mem[3], 32'hCAFE0003);
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; b_we = 0;
    rst_n = 1'b1;
    step(1, 0, 0, 7, 0, 1, 0, 0, 8, 0);
    chk("post_rst_conf_a", 32'(last_ga), 1);
    idle(2);

    // Back-to-back reads from A
    na = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 32'(i), 0, 0, 0, 0, 0, 0);
      if (last_ga) na++;
    end
    idle(2);
    chk("b2b_grants", 32'(na), 4);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           32'($urandom_range(0, DEPTH + 7)), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           32'($urandom_range(0, DEPTH + 7)), $urandom);
    end
    idle(3);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    cmp_mem("final_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
